// File: rtl/tree_encode_pkg.sv
// tree_encode_pkg: shared types and constants for the tree_encode block.
//   state_t   - controller states
//   NODE_BASE - byte address of the record for internal node 128
//   LEAF_LIMIT- child values below this are leaf symbols
//   CODE_BASE - code table lives at CODE_BASE + symbol
//   SENTINEL  - weight byte marking the record past the root
//   MAX_DEPTH - deepest code length supported (stack entries)
//   rec_addr  - byte address of (node, offset) inside the node records
package tree_encode_pkg;

    typedef enum logic [3:0] {
        IDLE,
        FIND_END,
        RWAIT,
        CHECK_END,
        DIG_ISSUE,
        DWAIT,
        DCHECK,
        STORE_CODE,
        SWAIT,
        STORE_CNT,
        CWAIT,
        FINISH
    } state_t;

    localparam logic [9:0] NODE_BASE  = 10'd256;
    localparam logic [7:0] LEAF_LIMIT = 8'd128;
    localparam logic [7:0] CODE_BASE  = 8'd128;
    localparam logic [7:0] SENTINEL   = 8'hFF;
    localparam logic [3:0] MAX_DEPTH  = 4'd8;
    localparam int         STACK_DEPTH = 8;

    // Node n occupies three bytes starting at NODE_BASE + 3*(n-128).
    function automatic logic [9:0] rec_addr(input logic [7:0] node, input logic [1:0] off);
        logic [9:0] idx;
        idx = {2'b00, node} - {2'b00, LEAF_LIMIT};
        return NODE_BASE + (idx << 1) + idx + {8'd0, off};
    endfunction

endpackage

// File: rtl/tree_encode_stack.sv
// tree_encode_stack: depth-first path stack, 8 entries of {node, offset}.
//   clk, reset  - clock and synchronous active-high reset
//   clr         - empty the stack
//   push        - push push_node with offset 2 (ignored when full)
//   pop         - drop the top entry
//   dec         - decrement the offset of the top entry; when issued
//                 together with pop it applies to the new top (the parent)
//   top_node/top_off - current top entry
//   depth       - number of entries held (0..8)
module tree_encode_stack
    import tree_encode_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       push,
    input  logic       pop,
    input  logic       dec,
    input  logic [7:0] push_node,
    output logic [7:0] top_node,
    output logic [1:0] top_off,
    output logic [3:0] depth
);

    logic [3:0]                 sp_q, sp_d;
    logic [3:0]                 dec_idx;
    logic [3:0]                 top_idx;
    logic [STACK_DEPTH*8-1:0]   node_flat;
    logic [STACK_DEPTH*2-1:0]   off_flat;

    always_comb begin
        sp_d = sp_q;
        if (clr) begin
            sp_d = 4'd0;
        end else if (push && (sp_q < MAX_DEPTH)) begin
            sp_d = sp_q + 4'd1;
        end else if (pop && (sp_q != 4'd0)) begin
            sp_d = sp_q - 4'd1;
        end
        // A combined pop+dec targets the entry below the current top.
        dec_idx = pop ? (sp_q - 4'd2) : (sp_q - 4'd1);
        top_idx = sp_q - 4'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sp_q <= 4'd0;
        end else begin
            sp_q <= sp_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < STACK_DEPTH; gi++) begin : g_entry
            logic [7:0] node_q, node_d;
            logic [1:0] off_q, off_d;

            always_comb begin
                node_d = node_q;
                off_d  = off_q;
                if (clr) begin
                    node_d = 8'd0;
                    off_d  = 2'd0;
                end else if (push && (sp_q == 4'(gi))) begin
                    node_d = push_node;
                    off_d  = 2'd2;
                end else if (dec && (dec_idx == 4'(gi)) && (off_q != 2'd0)) begin
                    off_d  = off_q - 2'd1;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    node_q <= 8'd0;
                    off_q  <= 2'd0;
                end else begin
                    node_q <= node_d;
                    off_q  <= off_d;
                end
            end

            assign node_flat[gi*8 +: 8] = node_q;
            assign off_flat[gi*2 +: 2]  = off_q;
        end
    endgenerate

    assign top_node = node_flat[top_idx[2:0]*8 +: 8];
    assign top_off  = off_flat[top_idx[2:0]*2 +: 2];
    assign depth    = sp_q;

endmodule

// File: rtl/tree_encode.sv
// tree_encode: walks a Huffman tree held in byte memory and writes a
// left-justified code and a length for every leaf symbol.
//   clk, reset        - clock and synchronous active-high reset
//   const_tree_start  - start request, honoured only while idle
//   search_node_data  - read data, valid in the second cycle of a read
//   const_tree_addr   - memory address for reads and writes
//   CT_R / CT_W       - read / write strobes (2-cycle accesses)
//   RC_data           - write data
//   const_tree_finish - one-cycle pulse when the code table is complete
// Optional: define TREE_ENCODE_ASSERT_EN to include simulation assertions.
module tree_encode
    import tree_encode_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       const_tree_start,
    input  logic [7:0] search_node_data,
    output logic [9:0] const_tree_addr,
    output logic       CT_R,
    output logic       CT_W,
    output logic [7:0] RC_data,
    output logic       const_tree_finish
);

    state_t     state_q, state_d;
    logic [7:0] scan_q, scan_d;     // node being probed for the sentinel
    logic [7:0] data_q, data_d;     // byte captured in the read wait cycle
    logic [7:0] path_q, path_d;     // branch bits of the ancestors, MSB first
    logic [7:0] sym_q, sym_d;
    logic [7:0] code_q, code_d;
    logic [3:0] len_q, len_d;

    logic       st_clr, st_push, st_pop, st_dec;
    logic [7:0] st_push_node;
    logic [7:0] top_node;
    logic [1:0] top_off;
    logic [3:0] depth;

    logic       branch;
    logic [7:0] bit_mask;   // bit owned by a child of the top node
    logic [7:0] keep_mask;  // bits owned by the ancestors of that child

    tree_encode_stack u_stack (
        .clk       (clk),
        .reset     (reset),
        .clr       (st_clr),
        .push      (st_push),
        .pop       (st_pop),
        .dec       (st_dec),
        .push_node (st_push_node),
        .top_node  (top_node),
        .top_off   (top_off),
        .depth     (depth)
    );

    always_comb begin
        state_d      = state_q;
        scan_d       = scan_q;
        data_d       = data_q;
        path_d       = path_q;
        sym_d        = sym_q;
        code_d       = code_q;
        len_d        = len_q;
        st_clr       = 1'b0;
        st_push      = 1'b0;
        st_pop       = 1'b0;
        st_dec       = 1'b0;
        st_push_node = data_q;
        branch       = top_off[1];
        bit_mask     = 8'h80 >> (depth - 4'd1);
        keep_mask    = ~(8'hFF >> (depth - 4'd1));

        case (state_q)
            IDLE: begin
                if (const_tree_start) begin
                    scan_d  = LEAF_LIMIT;
                    st_clr  = 1'b1;
                    state_d = FIND_END;
                end
            end
            FIND_END: state_d = RWAIT;
            RWAIT: begin
                data_d  = search_node_data;
                state_d = CHECK_END;
            end
            CHECK_END: begin
                if (data_q == SENTINEL) begin
                    if (scan_q == LEAF_LIMIT) begin
                        state_d = FINISH;           // empty tree
                    end else begin
                        st_push      = 1'b1;
                        st_push_node = scan_q - 8'd1;
                        path_d       = 8'd0;
                        state_d      = DIG_ISSUE;
                    end
                end else if (scan_q == 8'hFF) begin
                    state_d = FINISH;               // node space exhausted, no sentinel
                end else begin
                    scan_d  = scan_q + 8'd1;
                    state_d = FIND_END;
                end
            end
            DIG_ISSUE: state_d = DWAIT;
            DWAIT: begin
                data_d  = search_node_data;
                state_d = DCHECK;
            end
            DCHECK: begin
                if (top_off == 2'd0) begin
                    if (depth == 4'd1) begin
                        st_clr  = 1'b1;
                        state_d = FINISH;
                    end else begin
                        st_pop  = 1'b1;
                        st_dec  = 1'b1;
                        state_d = DIG_ISSUE;
                    end
                end else if (data_q >= LEAF_LIMIT) begin
                    // A child at the maximum depth cannot hold a code: skip it.
                    if (depth >= MAX_DEPTH) begin
                        st_dec = 1'b1;
                    end else begin
                        st_push = 1'b1;
                        path_d  = (path_q & ~bit_mask) | (branch ? bit_mask : 8'h00);
                    end
                    state_d = DIG_ISSUE;
                end else begin
                    sym_d   = data_q;
                    code_d  = (path_q & keep_mask) | (branch ? bit_mask : 8'h00);
                    len_d   = depth;
                    state_d = STORE_CODE;
                end
            end
            STORE_CODE: state_d = SWAIT;
            SWAIT:      state_d = STORE_CNT;
            STORE_CNT:  state_d = CWAIT;
            CWAIT: begin
                st_dec  = 1'b1;
                state_d = DIG_ISSUE;
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            scan_q  <= 8'd0;
            data_q  <= 8'd0;
            path_q  <= 8'd0;
            sym_q   <= 8'd0;
            code_q  <= 8'd0;
            len_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            scan_q  <= scan_d;
            data_q  <= data_d;
            path_q  <= path_d;
            sym_q   <= sym_d;
            code_q  <= code_d;
            len_q   <= len_d;
        end
    end

    // Outputs depend only on the state and registered values.
    always_comb begin
        const_tree_addr   = 10'd0;
        CT_R              = 1'b0;
        CT_W              = 1'b0;
        RC_data           = 8'd0;
        const_tree_finish = 1'b0;
        case (state_q)
            FIND_END, RWAIT: begin
                CT_R            = 1'b1;
                const_tree_addr = rec_addr(scan_q, 2'd0);
            end
            DIG_ISSUE, DWAIT: begin
                CT_R            = 1'b1;
                const_tree_addr = rec_addr(top_node, top_off);
            end
            STORE_CODE, SWAIT: begin
                CT_W            = 1'b1;
                const_tree_addr = {2'b00, CODE_BASE} + {2'b00, sym_q};
                RC_data         = code_q;
            end
            STORE_CNT, CWAIT: begin
                CT_W            = 1'b1;
                const_tree_addr = {2'b00, sym_q};
                RC_data         = {4'd0, len_q};
            end
            FINISH:  const_tree_finish = 1'b1;
            default: ;
        endcase
    end

`ifdef TREE_ENCODE_ASSERT_EN
    logic finish_prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            finish_prev_q <= 1'b0;
        end else begin
            finish_prev_q <= const_tree_finish;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(CT_R && CT_W));
            assert (depth <= MAX_DEPTH);
            assert (!(finish_prev_q && const_tree_finish));
            assert (!(CT_R || CT_W) || ({1'b0, const_tree_addr} < 11'd1024));
        end
    end
`else
    // Assertions excluded from this build.
`endif

endmodule

// File: tb/tb_tree_encode.sv
`timescale 1ns/1ps
module tb_tree_encode;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       const_tree_start = 1'b0;
    logic [7:0] search_node_data;
    logic [9:0] const_tree_addr;
    logic       CT_R;
    logic       CT_W;
    logic [7:0] RC_data;
    logic       const_tree_finish;

    tree_encode dut (
        .clk               (clk),
        .reset             (reset),
        .const_tree_start  (const_tree_start),
        .search_node_data  (search_node_data),
        .const_tree_addr   (const_tree_addr),
        .CT_R              (CT_R),
        .CT_W              (CT_W),
        .RC_data           (RC_data),
        .const_tree_finish (const_tree_finish)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [1024];
    assign search_node_data = mem[const_tree_addr];

    typedef struct packed {
        logic [9:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t        exp_q [$];
    logic [9:0] rd_log [$];
    int         n_vec = 0;
    int         n_err = 0;

    int  main_addr [12] = '{133, 5, 129, 1, 130, 2, 132, 4, 128, 0, 131, 3};
    int  main_data [12] = '{8'hC0, 2, 8'hB0, 4, 8'hA0, 4, 8'h80, 3, 8'h40, 2, 8'h00, 2};

    // Bus monitor / scoreboard: each access spans two cycles with stable
    // address (and data); it is logged on its second cycle.
    int         w_phase = 0;
    int         r_phase = 0;
    logic [9:0] w_addr;
    logic [7:0] w_data;
    logic [9:0] r_addr;

    always @(negedge clk) begin
        wr_t e;
        if (CT_R && CT_W) begin
            n_vec++;
            n_err++;
            $display("FAIL strobe_excl: CT_R=%0b CT_W=%0b, required not both high", CT_R, CT_W);
        end
        if (CT_W) begin
            if (w_phase == 0) begin
                w_addr  = const_tree_addr;
                w_data  = RC_data;
                w_phase = 1;
            end else begin
                w_phase = 0;
                n_vec++;
                if (const_tree_addr !== w_addr || RC_data !== w_data) begin
                    n_err++;
                    $display("FAIL write_hold: got [%0d]=%02h, required held [%0d]=%02h",
                             const_tree_addr, RC_data, w_addr, w_data);
                end else if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL write_unexpected: got [%0d]=%02h, required no write",
                             const_tree_addr, RC_data);
                end else begin
                    e = exp_q.pop_front();
                    if (e.addr !== const_tree_addr || e.data !== RC_data) begin
                        n_err++;
                        $display("FAIL write_seq: got [%0d]=%02h, required [%0d]=%02h",
                                 const_tree_addr, RC_data, e.addr, e.data);
                    end else begin
                        $display("write [%0d]=%02h ok", const_tree_addr, RC_data);
                    end
                end
            end
        end else begin
            w_phase = 0;
        end
        if (CT_R) begin
            if (r_phase == 0) begin
                r_addr  = const_tree_addr;
                r_phase = 1;
            end else begin
                r_phase = 0;
                rd_log.push_back(r_addr);
            end
        end else begin
            r_phase = 0;
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    endtask

    task automatic load_main_tree();
        clear_mem();
        // node 128..132 at 256, 259, 262, 265, 268; sentinel at 271
        mem[256] = 8'd1;  mem[257] = 8'd2;   mem[258] = 8'd1;
        mem[259] = 8'd1;  mem[260] = 8'd4;   mem[261] = 8'd128;
        mem[262] = 8'd1;  mem[263] = 8'd3;   mem[264] = 8'd0;
        mem[265] = 8'd1;  mem[266] = 8'd129; mem[267] = 8'd5;
        mem[268] = 8'd23; mem[269] = 8'd130; mem[270] = 8'd131;
        mem[271] = 8'hFF;
    endtask

    task automatic push_main_expect();
        wr_t e;
        for (int i = 0; i < 12; i++) begin
            e.addr = main_addr[i][9:0];
            e.data = main_data[i][7:0];
            exp_q.push_back(e);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) const_tree_start = 1'b1;
        @(negedge clk) const_tree_start = 1'b0;
    endtask

    task automatic wait_finish(input int budget, output int cyc, output logic after);
        cyc   = -1;
        after = 1'bx;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (const_tree_finish) begin
                cyc = i;
                @(negedge clk);
                after = const_tree_finish;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++; if (const_tree_addr !== 10'd0) begin n_err++; $display("FAIL reset_addr: got %0d, required 0", const_tree_addr); end
        n_vec++; if (CT_R !== 1'b0) begin n_err++; $display("FAIL reset_ctr: got %0b, required 0", CT_R); end
        n_vec++; if (CT_W !== 1'b0) begin n_err++; $display("FAIL reset_ctw: got %0b, required 0", CT_W); end
        n_vec++; if (RC_data !== 8'd0) begin n_err++; $display("FAIL reset_data: got %02h, required 00", RC_data); end
        n_vec++; if (const_tree_finish !== 1'b0) begin n_err++; $display("FAIL reset_finish: got %0b, required 0", const_tree_finish); end
        reset = 1'b0;
        @(negedge clk);
        $display("test_reset done");
    endtask

    // Checks shared by the full-tree runs, written out per test.
    task automatic test_main_tree();
        int   cyc;
        logic after;
        load_main_tree();
        exp_q.delete();
        rd_log.delete();
        push_main_expect();
        pulse_start();
        wait_finish(2000, cyc, after);
        n_vec++; if (cyc < 0) begin n_err++; $display("FAIL main_finish: got timeout, required finish pulse"); end
        n_vec++; if (after !== 1'b0) begin n_err++; $display("FAIL main_pulse_width: got finish=%0b after 1 cycle, required 0", after); end
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL main_writes_left: got %0d pending, required 0", exp_q.size()); end
        for (int k = 0; k < 6; k++) begin
            n_vec++;
            if (rd_log.size() <= k || rd_log[k] !== 10'(256 + 3 * k)) begin
                n_err++;
                $display("FAIL main_scan_read%0d: got %0d, required %0d", k,
                         (rd_log.size() > k) ? int'(rd_log[k]) : -1, 256 + 3 * k);
            end
        end
        n_vec++;
        if (rd_log.size() == 0 || rd_log[rd_log.size() - 1] !== 10'd268) begin
            n_err++;
            $display("FAIL main_last_read: got %0d, required 268",
                     (rd_log.size() > 0) ? int'(rd_log[rd_log.size() - 1]) : -1);
        end
        $display("test_main_tree done, %0d reads", rd_log.size());
    endtask

    task automatic test_sentinel_first();
        int   cyc;
        logic after;
        clear_mem();
        mem[256] = 8'hFF;
        exp_q.delete();
        rd_log.delete();
        pulse_start();
        wait_finish(200, cyc, after);
        n_vec++; if (cyc < 0) begin n_err++; $display("FAIL empty_finish: got timeout, required finish pulse"); end
        n_vec++; if (after !== 1'b0) begin n_err++; $display("FAIL empty_pulse_width: got %0b, required 0", after); end
        n_vec++; if (rd_log.size() != 1) begin n_err++; $display("FAIL empty_read_count: got %0d, required 1", rd_log.size()); end
        n_vec++;
        if (rd_log.size() == 0 || rd_log[0] !== 10'd256) begin
            n_err++;
            $display("FAIL empty_read_addr: got %0d, required 256", (rd_log.size() > 0) ? int'(rd_log[0]) : -1);
        end
        $display("test_sentinel_first done");
    endtask

    task automatic test_start_toggle();
        int   cyc;
        logic after;
        load_main_tree();
        exp_q.delete();
        rd_log.delete();
        push_main_expect();
        pulse_start();
        fork
            wait_finish(2000, cyc, after);
            begin
                repeat (40) @(negedge clk) const_tree_start = ~const_tree_start;
                const_tree_start = 1'b0;
            end
        join
        n_vec++; if (cyc < 0) begin n_err++; $display("FAIL toggle_finish: got timeout, required finish pulse"); end
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL toggle_writes_left: got %0d pending, required 0", exp_q.size()); end
        n_vec++;
        if (rd_log.size() == 0 || rd_log[rd_log.size() - 1] !== 10'd268) begin
            n_err++;
            $display("FAIL toggle_last_read: got %0d, required 268",
                     (rd_log.size() > 0) ? int'(rd_log[rd_log.size() - 1]) : -1);
        end
        repeat (3) @(negedge clk);
        n_vec++; if (CT_R !== 1'b0) begin n_err++; $display("FAIL toggle_idle_after: got CT_R=%0b, required 0", CT_R); end
        $display("test_start_toggle done");
    endtask

    task automatic test_reset_mid_write();
        int   seen;
        seen = 0;
        load_main_tree();
        exp_q.delete();
        rd_log.delete();
        push_main_expect();
        pulse_start();
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (CT_W) begin seen = 1; break; end
        end
        n_vec++; if (seen == 0) begin n_err++; $display("FAIL abort_write_seen: got no write, required a write"); end
        reset = 1'b1;
        @(negedge clk);
        n_vec++;
        if (const_tree_addr !== 10'd0 || CT_R !== 1'b0 || CT_W !== 1'b0 || RC_data !== 8'd0 || const_tree_finish !== 1'b0) begin
            n_err++;
            $display("FAIL abort_outputs: got addr=%0d r=%0b w=%0b data=%02h fin=%0b, required all 0",
                     const_tree_addr, CT_R, CT_W, RC_data, const_tree_finish);
        end
        reset = 1'b0;
        exp_q.delete();
        repeat (4) @(negedge clk);
        n_vec++; if (CT_R !== 1'b0 || CT_W !== 1'b0) begin n_err++; $display("FAIL abort_quiet: got r=%0b w=%0b, required 0 0", CT_R, CT_W); end
        $display("test_reset_mid_write abort done");
        test_main_tree();
    endtask

    // Chain: node 136-k sits at depth k with leaf k on the left and the next
    // node on the right. Node 128 would sit at depth 8 and must be skipped.
    task automatic test_depth_limit();
        int         cyc;
        logic       after;
        int         base;
        wr_t        e;
        logic [7:0] code;
        clear_mem();
        for (int k = 0; k <= 8; k++) begin
            base = 3 * (136 - k) - 128;
            mem[base]     = 8'd1;
            mem[base + 1] = 8'(k);
            mem[base + 2] = (k < 8) ? 8'(135 - k) : 8'd9;
        end
        mem[3 * 137 - 128] = 8'hFF;
        exp_q.delete();
        rd_log.delete();
        for (int k = 7; k >= 0; k--) begin
            code = 8'h00;
            for (int j = 0; j < k; j++) code[7 - j] = 1'b1;
            e.addr = 10'(128 + k); e.data = code;      exp_q.push_back(e);
            e.addr = 10'(k);       e.data = 8'(k + 1); exp_q.push_back(e);
        end
        pulse_start();
        wait_finish(3000, cyc, after);
        n_vec++; if (cyc < 0) begin n_err++; $display("FAIL chain_finish: got timeout, required finish pulse"); end
        n_vec++; if (after !== 1'b0) begin n_err++; $display("FAIL chain_pulse_width: got %0b, required 0", after); end
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL chain_writes_left: got %0d pending, required 0", exp_q.size()); end
        $display("test_depth_limit done");
    endtask

    initial begin
        clear_mem();
        test_reset();
        test_main_tree();
        test_sentinel_first();
        test_start_toggle();
        test_reset_mid_write();
        test_depth_limit();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tree_encode.md
TREE_ENCODE -- requirements
Module: tree_encode

Interface
REQ-001 SHALL have the ports below; one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 const_tree_start  input  1  start request, sampled in IDLE only.
REQ-005 search_node_data  input  8  memory read data, valid in the WAIT cycle of a read.
REQ-006 const_tree_addr  output  10  memory address for reads and writes.
REQ-007 CT_R  output  1  read strobe.
REQ-008 CT_W  output  1  write strobe.
REQ-009 RC_data  output  8  memory write data.
REQ-010 const_tree_finish  output  1  pulses high for one cycle when the code table is complete.

Function
REQ-011 Memory map: internal node n (128..255) is a 3-byte record at 3n-128 (n=128 maps to 256). Offset 0 = weight/sentinel, +1 = left child, +2 = right child. A child value below 128 is a leaf symbol; 128 or above is an internal node.
REQ-012 Outputs SHALL be Moore: driven from state and registers, stable for the whole cycle. CT_R and CT_W SHALL never both be high.
REQ-013 Every read SHALL take 3 cycles: ISSUE (CT_R=1, address driven), WAIT (CT_R=1, same address, data sampled), CHECK (decision).
REQ-014 Every write SHALL take 2 cycles (CT_W=1, address and RC_data held for both).
REQ-015 IDLE: when start=1 at a clock edge, go to FIND_END.
REQ-016 Scan phase: read offset 0 of nodes 128, 129, ... in turn. When the data equals 8'hFF, that record is the sentinel, and the root is the previous node.
REQ-017 Traversal SHALL be depth-first with a per-level path stack holding {node, offset}. Each newly entered level starts at offset 2. At each step the block reads node+offset.
REQ-018 In CHECK, if offset is 0: pop. The data read is ignored. If at the root, go to FINISH. Otherwise return to the parent and decrement the parent's offset.
REQ-019 In CHECK, if offset is nonzero: the branch bit is 1 for offset 2 and 0 for offset 1.
- An internal child is pushed; its code bit goes at position 7-depth.
- A leaf child s causes two writes: first the code to address 128+s, then the length to address s. After that the offset is decremented and the same level is read again.
REQ-020 Codes are MSB-first, left-justified, with unused low bits 0. Length = number of bits = leaf depth (root children have depth 1).
REQ-021 Maximum depth is 8. An internal child found at depth 8 SHALL be skipped (offset decremented, no push).
REQ-022 If the first record (address 256) is 8'hFF, the block SHALL go straight to FINISH with no writes.
REQ-023 FINISH: const_tree_finish=1 for one cycle, then return to IDLE.

Reset
REQ-024 Reset SHALL apply state IDLE with all outputs 0 (address 0, CT_R=0, CT_W=0, RC_data=0, finish=0), and SHALL clear the stack and depth.
REQ-025 Reset asserted mid-operation SHALL abort the operation at the next edge with no further memory access.

Configuration
REQ-026 TREE_ENCODE_ASSERT_EN defined: simulation assertions are included, covering:
- CT_R and CT_W never both high;
- depth never exceeds 8;
- const_tree_finish lasts exactly one cycle;
- const_tree_addr is always below 1024 during accesses.
Undefined: no assertions, and identical RTL behaviour.

Structure
REQ-027 Package tree_encode_pkg SHALL hold:
- the state enum (IDLE, FIND_END, RWAIT, CHECK_END, DIG_ISSUE, DWAIT, DCHECK, STORE_CODE, SWAIT, STORE_CNT, CWAIT, FINISH);
- constants NODE_BASE=256, LEAF_LIMIT=128, CODE_BASE=128, SENTINEL=8'hFF, MAX_DEPTH=8.
REQ-028 The path stack (8 entries of {node[7:0], offset[1:0]}, with push, pop and decrement) SHALL be sub-module tree_encode_stack.

Verification
REQ-029 Build the tree 128={_,2,1}, 129={_,4,128}, 130={_,3,0}, 131={_,129,5}, 132={23,130,131}, sentinel 0xFF at 271, then start. The block SHALL read 256, 259, 262, 265, 268, 271. It SHALL then write, in this order:
- [133]=C0, [5]=2
- [129]=B0, [1]=4
- [130]=A0, [2]=4
- [132]=80, [4]=3
- [128]=40, [0]=2
- [131]=00, [3]=2
The last read SHALL be 268, followed by a one-cycle finish pulse.
REQ-030 Sentinel at 256: exactly one read, no writes, then the finish pulse.
REQ-031 Toggle start during traversal: it SHALL be ignored and the write sequence SHALL be unchanged.
REQ-032 Assert reset during a write: the next cycle SHALL be IDLE with all outputs 0. A new start SHALL then reproduce the REQ-029 sequence.
REQ-033 Chain tree of depth 9: the level-9 subtree SHALL be skipped, the remaining leaves SHALL be encoded with lengths up to 8, and the block SHALL finish.
